// File: rtl/rans_enc_mlane.sv
// rtl/rans_enc_mlane.sv - interleaved multi-lane rANS encoder; optional RANS_ENC_FREQ_CHECK_EN adds zero-frequency detection
module rans_enc_mlane #(
    parameter int RESOLUTION   = 10,
    parameter int SYMBOL_WIDTH = 8,
    parameter int LANES        = 2
) (
    input  logic                                       clk_i,
    input  logic                                       rst_i,
    input  logic                                       valid_i,
    input  logic [SYMBOL_WIDTH-1:0]                    symb_i,
    input  logic                                       restart_i,
    input  logic                                       freq_wr_i,
    input  logic [SYMBOL_WIDTH-1:0]                    freq_addr_i,
    input  logic [RESOLUTION-1:0]                      freq_i,
    input  logic [RESOLUTION-1:0]                      cum_freq_i,
    output logic                                       ready_o,
    input  logic                                       ready_i,
    output logic [1:0]                                 valid_o,
    output logic [2*SYMBOL_WIDTH-1:0]                  enc_o,
    output logic [(LANES > 1 ? $clog2(LANES) : 1)-1:0] lane_o,
    output logic                                       error_o
);

    localparam int WORD_W  = 2 * SYMBOL_WIDTH;
    localparam int STATE_W = 4 * SYMBOL_WIDTH;
    localparam logic [STATE_W:0] L = (STATE_W + 1)'(1) << WORD_W;
    localparam int LANE_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int TAB_D   = 1 << SYMBOL_WIDTH;
    localparam int CNT_W   = $clog2(STATE_W);

    // Renormalisation threshold per unit of frequency; x_max = X_UNIT * freq.
    localparam logic [STATE_W:0]   X_UNIT    = (L >> RESOLUTION) << WORD_W;
    localparam logic [STATE_W-1:0] X_INIT    = STATE_W'(L);
    localparam logic [LANE_W-1:0]  LANE_LAST = LANE_W'(LANES - 1);

    typedef enum logic [2:0] {IDLE, LOOKUP, RENORM, DIV, UPDATE, FLUSH} state_t;

    state_t state_q, state_d;

    logic [RESOLUTION-1:0] freq_tab [TAB_D];
    logic [RESOLUTION-1:0] cum_tab  [TAB_D];

    logic [STATE_W-1:0]    x_q [LANES];
    logic [LANE_W-1:0]     lane_ptr;
    logic [RESOLUTION-1:0] freq_r;
    logic [RESOLUTION-1:0] cum_r;
    logic [STATE_W-1:0]    div_q;
    logic [RESOLUTION-1:0] div_r;
    logic [CNT_W-1:0]      div_cnt;
    logic [LANE_W-1:0]     fl_lane;
    logic                  fl_hi;

    logic [STATE_W-1:0]    x_cur;
    logic [STATE_W:0]      x_max;
    logic                  emit;
    logic [RESOLUTION:0]   rem_sh;
    logic                  rem_ge;
    logic [RESOLUTION-1:0] rem_sub;
    logic [STATE_W-1:0]    x_new;
    logic [STATE_W-1:0]    fl_x;
    logic [WORD_W-1:0]     fl_word;

    assign x_cur   = x_q[lane_ptr];
    assign x_max   = X_UNIT * {{(STATE_W + 1 - RESOLUTION){1'b0}}, freq_r};
    assign emit    = ({1'b0, x_cur} >= x_max);
    // One restoring-divide step: shift the next dividend bit into the partial remainder.
    assign rem_sh  = {div_r, div_q[STATE_W-1]};
    assign rem_ge  = (rem_sh >= {1'b0, freq_r});
    assign rem_sub = RESOLUTION'(rem_sh - {1'b0, freq_r});
    assign x_new   = (div_q << RESOLUTION) + STATE_W'(div_r) + STATE_W'(cum_r);
    assign fl_x    = x_q[fl_lane];
    assign fl_word = fl_hi ? fl_x[STATE_W-1:WORD_W] : fl_x[WORD_W-1:0];

    // Frequency table write port; contents intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (freq_wr_i && ready_o) begin
            freq_tab[freq_addr_i] <= freq_i;
            cum_tab[freq_addr_i]  <= cum_freq_i;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode and all block outputs.
    always_comb begin
        state_d = state_q;
        ready_o = 1'b0;
        valid_o = 2'b00;
        enc_o   = '0;
        lane_o  = '0;
        error_o = 1'b0;
        case (state_q)
            IDLE: begin
                ready_o = !rst_i;
                if (restart_i) begin
                    state_d = FLUSH;
                end else if (valid_i) begin
                    state_d = LOOKUP;
                end
            end
            LOOKUP: begin
`ifdef RANS_ENC_FREQ_CHECK_EN
                if (freq_r == '0) begin
                    error_o = 1'b1;
                    state_d = IDLE;
                end else begin
                    state_d = RENORM;
                end
`else
                state_d = RENORM;
`endif
            end
            RENORM: begin
                if (emit) begin
                    valid_o = 2'b01;
                    enc_o   = x_cur[WORD_W-1:0];
                    lane_o  = lane_ptr;
                    if (ready_i) begin
                        state_d = DIV;
                    end
                end else begin
                    state_d = DIV;
                end
            end
            DIV: begin
                if (div_cnt == CNT_W'(STATE_W - 1)) begin
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                state_d = IDLE;
            end
            FLUSH: begin
                valid_o = 2'b10;
                enc_o   = fl_word;
                lane_o  = fl_lane;
                if (ready_i && fl_hi && (fl_lane == LANE_LAST)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Lane states, divider and flush sequencing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < LANES; i++) begin
                x_q[i] <= X_INIT;
            end
            lane_ptr <= '0;
            freq_r   <= '0;
            cum_r    <= '0;
            div_q    <= '0;
            div_r    <= '0;
            div_cnt  <= '0;
            fl_lane  <= '0;
            fl_hi    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (restart_i) begin
                        fl_lane <= '0;
                        fl_hi   <= 1'b0;
                    end else if (valid_i) begin
                        // Read at acceptance so a coincident table write is not seen.
                        freq_r <= freq_tab[symb_i];
                        cum_r  <= cum_tab[symb_i];
                    end
                end
                RENORM: begin
                    if (!emit || ready_i) begin
                        div_q   <= emit ? (x_cur >> WORD_W) : x_cur;
                        div_r   <= '0;
                        div_cnt <= '0;
                        if (emit) begin
                            x_q[lane_ptr] <= x_cur >> WORD_W;
                        end
                    end
                end
                DIV: begin
                    div_q   <= {div_q[STATE_W-2:0], rem_ge};
                    div_r   <= rem_ge ? rem_sub : rem_sh[RESOLUTION-1:0];
                    div_cnt <= div_cnt + 1'b1;
                end
                UPDATE: begin
                    x_q[lane_ptr] <= x_new;
                    lane_ptr      <= (lane_ptr == LANE_LAST) ? '0 : lane_ptr + 1'b1;
                end
                FLUSH: begin
                    if (ready_i) begin
                        if (fl_hi) begin
                            fl_hi <= 1'b0;
                            if (fl_lane == LANE_LAST) begin
                                for (int i = 0; i < LANES; i++) begin
                                    x_q[i] <= X_INIT;
                                end
                                lane_ptr <= '0;
                            end else begin
                                fl_lane <= fl_lane + 1'b1;
                            end
                        end else begin
                            fl_hi <= 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rans_enc_mlane.sv
// tb/tb_rans_enc_mlane.sv - scoreboard bench for rans_enc_mlane
`timescale 1ns/1ps
module tb_rans_enc_mlane;

    localparam int LANES = 2;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic [7:0]  symb_i;
    logic        restart_i;
    logic        freq_wr_i;
    logic [7:0]  freq_addr_i;
    logic [9:0]  freq_i;
    logic [9:0]  cum_freq_i;
    logic        ready_o;
    logic        ready_i;
    logic [1:0]  valid_o;
    logic [15:0] enc_o;
    logic [0:0]  lane_o;
    logic        error_o;

    rans_enc_mlane #(.RESOLUTION(10), .SYMBOL_WIDTH(8), .LANES(LANES)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .symb_i(symb_i),
        .restart_i(restart_i), .freq_wr_i(freq_wr_i), .freq_addr_i(freq_addr_i),
        .freq_i(freq_i), .cum_freq_i(cum_freq_i), .ready_o(ready_o), .ready_i(ready_i),
        .valid_o(valid_o), .enc_o(enc_o), .lane_o(lane_o), .error_o(error_o)
    );

    always #5 clk_i = ~clk_i;

    int n_tests = 0;
    int n_fail  = 0;
    int err_seen = 0;
    int exp_err  = 0;

    longint unsigned mx [LANES];
    int              mptr;
    longint unsigned mf [256];
    longint unsigned mc [256];
    logic [63:0]     exp_q [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int v, input int lane, input longint unsigned w);
        return (64'(v) << 17) | (64'(lane) << 16) | 64'(w & 64'hFFFF);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < LANES; i++) mx[i] = 64'd65536;
        mptr = 0;
    endfunction

    function automatic void model_encode(input int s);
        longint unsigned x = mx[mptr];
        longint unsigned f = mf[s];
        if (x >= (f * 64'd4194304)) begin
            exp_q.push_back(pack(1, mptr, x));
            x = x >> 16;
        end
        mx[mptr] = ((x / f) * 64'd1024) + (x % f) + mc[s];
        mptr = (mptr + 1) % LANES;
    endfunction

    function automatic void model_flush();
        for (int i = 0; i < LANES; i++) begin
            exp_q.push_back(pack(2, i, mx[i]));
            exp_q.push_back(pack(2, i, mx[i] >> 16));
        end
        model_reset();
    endfunction

    // Output monitor: every transferred word is popped from the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (error_o) err_seen++;
            if (valid_o != 2'b00 && ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_word", {45'd0, valid_o, lane_o, enc_o}, 64'd0);
                end else begin
                    check("word", {45'd0, valid_o, lane_o, enc_o}, exp_q.pop_front());
                end
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!ready_o && n < 2000) begin
            @(posedge clk_i); #1;
            n++;
        end
        if (!ready_o) check("ready_timeout", {63'd0, ready_o}, 64'd1);
    endtask

    task automatic write_tab(input logic [7:0] a, input int f, input int c);
        wait_ready();
        freq_wr_i = 1'b1; freq_addr_i = a; freq_i = 10'(f); cum_freq_i = 10'(c);
        mf[a] = longint'(f); mc[a] = longint'(c);
        @(posedge clk_i); #1;
        freq_wr_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] s);
        int lat = 0;
        wait_ready();
        valid_i = 1'b1; symb_i = s;
        model_encode(int'(s));
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        while (!ready_o && lat < 2000) begin
            @(posedge clk_i); #1;
            lat++;
        end
        check("latency", 64'(lat), 64'd35);
    endtask

    task automatic restart(input bit with_sym);
        wait_ready();
        restart_i = 1'b1;
        if (with_sym) begin
            valid_i = 1'b1; symb_i = 8'h41;
        end
        model_flush();
        @(posedge clk_i); #1;
        restart_i = 1'b0; valid_i = 1'b0;
        wait_ready();
        check("flush_drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; symb_i = '0; restart_i = 1'b0;
        freq_wr_i = 1'b0; freq_addr_i = '0; freq_i = '0; cum_freq_i = '0; ready_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_valid", {62'd0, valid_o}, 64'd0);
        check("rst_enc", {48'd0, enc_o}, 64'd0);
        check("rst_lane", {63'd0, lane_o}, 64'd0);
        check("rst_error", {63'd0, error_o}, 64'd0);
        rst_i = 1'b0;
        @(posedge clk_i); #1;
        check("ready_after_rst", {63'd0, ready_o}, 64'd1);

        // Basic encode, flush, then flush of freshly initialised lanes.
        write_tab(8'h41, 512, 0);
        send(8'h41);
        restart(1'b0);
        restart(1'b0);

        // Renormalisation emit, with a stalled third symbol.
        write_tab(8'h07, 1, 5);
        send(8'h07);
        send(8'h07);
        ready_i = 1'b0;
        wait_ready();
        valid_i = 1'b1; symb_i = 8'h07;
        model_encode(7);
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        @(posedge clk_i); #1;
        for (int i = 0; i < 10; i++) begin
            check("stall_valid", {62'd0, valid_o}, 64'd1);
            check("stall_enc", {48'd0, enc_o}, 64'h0005);
            @(posedge clk_i); #1;
        end
        ready_i = 1'b1;
        wait_ready();
        restart(1'b0);

        // Restart wins over a simultaneous symbol.
        restart(1'b1);
        restart(1'b0);

        // Mixed frequencies, including a table write coinciding with acceptance.
        write_tab(8'h03, 300, 100);
        write_tab(8'hC8, 3, 1000);
        send(8'h03); send(8'hC8); send(8'hC8); send(8'h03);
        send(8'hC8); send(8'hC8); send(8'hC8);
        wait_ready();
        valid_i = 1'b1; symb_i = 8'h03;
        freq_wr_i = 1'b1; freq_addr_i = 8'h03; freq_i = 10'd5; cum_freq_i = 10'd10;
        model_encode(3);
        mf[3] = 5; mc[3] = 10;
        @(posedge clk_i); #1;
        valid_i = 1'b0; freq_wr_i = 1'b0;
        wait_ready();
        send(8'h03); send(8'hC8);
        restart(1'b0);

`ifdef RANS_ENC_FREQ_CHECK_EN
        exp_err = 1;
        write_tab(8'h09, 0, 0);
        wait_ready();
        valid_i = 1'b1; symb_i = 8'h09;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        check("err_pulse", {63'd0, error_o}, 64'd1);
        @(posedge clk_i); #1;
        check("err_clear", {63'd0, error_o}, 64'd0);
        check("err_ready", {63'd0, ready_o}, 64'd1);
        send(8'h41);
        restart(1'b0);
`endif

        // Reset in the middle of the divide abandons the symbol.
        wait_ready();
        valid_i = 1'b1; symb_i = 8'h41;
        @(posedge clk_i); #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        check("mid_rst_ready", {63'd0, ready_o}, 64'd0);
        check("mid_rst_valid", {62'd0, valid_o}, 64'd0);
        check("mid_rst_enc", {48'd0, enc_o}, 64'd0);
        check("mid_rst_lane", {63'd0, lane_o}, 64'd0);
        check("mid_rst_error", {63'd0, error_o}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        write_tab(8'h41, 512, 0);
        send(8'h41);
        restart(1'b0);

        repeat (5) @(posedge clk_i);
        #1;
        check("sb_empty", 64'(exp_q.size()), 64'd0);
        check("err_count", 64'(err_seen), 64'(exp_err));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rans_enc_mlane.md
RANS_ENC_MLANE -- requirements
Module: rans_enc_mlane

Interface
REQ-001 SHALL have parameter RESOLUTION, default 10, meaning the frequency-table precision in bits (total frequency 2^RESOLUTION).
REQ-002 SHALL have parameter SYMBOL_WIDTH, default 8, meaning the symbol width; table depth is 2^SYMBOL_WIDTH.
REQ-003 SHALL have parameter LANES, default 2, meaning the number of interleaved rANS states (1..8).
REQ-004 SHALL derive WORD_W = 2*SYMBOL_WIDTH, STATE_W = 4*SYMBOL_WIDTH and L = 2^WORD_W as localparams.
REQ-005 SHALL have port clk_i, input, 1 bit: the single clock.
REQ-006 SHALL have port rst_i, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port valid_i, input, 1 bit: symb_i is valid.
REQ-008 SHALL have port symb_i, input, SYMBOL_WIDTH bits: the symbol to encode.
REQ-009 SHALL have port restart_i, input, 1 bit: flush all lanes, then reinitialise.
REQ-010 SHALL have port freq_wr_i, input, 1 bit: write the table entry.
REQ-011 SHALL have port freq_addr_i, input, SYMBOL_WIDTH bits: the table write address.
REQ-012 SHALL have ports freq_i and cum_freq_i, input, RESOLUTION bits each: the frequency and cumulative frequency written to the table.
REQ-013 SHALL have port ready_o, output, 1 bit: the block accepts a symbol, restart or table write.
REQ-014 SHALL have port ready_i, input, 1 bit: downstream accepts enc_o.
REQ-015 SHALL have port valid_o, output, 2 bits: 00 = none, 01 = renormalisation word, 10 = flush word, 11 = never driven.
REQ-016 SHALL have port enc_o, output, WORD_W bits: the emitted word.
REQ-017 SHALL have port lane_o, output, clog2(LANES) bits (minimum 1): the lane that produced enc_o.
REQ-018 SHALL have port error_o, output, 1 bit: single-cycle zero-frequency error pulse (see Configuration).

Function
REQ-019 SHALL implement FSM states IDLE, LOOKUP, RENORM, DIV, UPDATE and FLUSH; ready_o SHALL be 1 only in IDLE.
REQ-020 SHALL accept a symbol on valid_i & ready_o & !restart_i, then go IDLE->LOOKUP.
REQ-021 SHALL assign symbol k (counted from reset or restart) to lane k mod LANES, using a wrapping lane pointer advanced in UPDATE.
REQ-022 LOOKUP SHALL read freq/cum for the symbol from the internal table in 1 cycle, then go ->RENORM.
REQ-023 RENORM SHALL compute x_max = ((L >> RESOLUTION) << WORD_W) * freq in full STATE_W+1 precision.
REQ-024 If x >= x_max, RENORM SHALL present valid_o=01, enc_o=x[WORD_W-1:0] and hold both stable until ready_i=1, then set x = x >> WORD_W; at most one word is emitted per symbol.
REQ-025 RENORM SHALL go ->DIV in the cycle after the word transfers, or after 1 cycle if no word is due.
REQ-026 DIV SHALL run an iterative restoring divide x/freq taking exactly STATE_W cycles, producing a quotient q and remainder r.
REQ-027 UPDATE SHALL write x = (q << RESOLUTION) + r + cum (STATE_W bits, no overflow by construction) and advance the lane pointer, then go ->IDLE.
REQ-028 With no output stall, ready_o SHALL reassert STATE_W+3 cycles after acceptance.
REQ-029 restart_i & ready_o SHALL enter FLUSH; restart SHALL have priority over a simultaneous valid_i, and that symbol is not accepted.
REQ-030 FLUSH SHALL emit valid_o=10 in lane order 0..LANES-1, low word then high word per lane, each held until ready_i.
REQ-031 After the last flush word, FLUSH SHALL set every lane state to L, reset the lane pointer to 0, and go ->IDLE.
REQ-032 freq_wr_i & ready_o SHALL write the table entry, visible to a symbol accepted in the next cycle or later; freq_wr_i is ignored when ready_o=0, and a write may coincide with symbol acceptance, in which case the accepted symbol sees the old entry.
REQ-033 valid_o SHALL be 00 in every state except RENORM-emit and FLUSH.

Reset
REQ-034 rst_i SHALL immediately force state IDLE, all lane states to L, lane pointer 0, valid_o=00, enc_o=0, lane_o=0, error_o=0 and ready_o=0 while asserted.
REQ-035 Reset mid-operation, including during a stalled emit, SHALL abandon the symbol or flush with no further output; table contents are undefined after reset.

Configuration
REQ-036 With macro RANS_ENC_FREQ_CHECK_EN defined, LOOKUP SHALL detect freq=0, pulse error_o for 1 cycle, drop the symbol without advancing the lane pointer, and return to IDLE.
REQ-037 Without RANS_ENC_FREQ_CHECK_EN, error_o SHALL be tied 0, no check SHALL be made, and freq=0 is a forbidden input.

Verification
REQ-038 Reset, write sym 0x41 freq=512 cum=0, send 0x41 -> no output, lane0 x=0x00020000, ready_o back after 35 cycles.
REQ-039 Then restart_i -> flush words 0x0000,0x0002 (lane 0), then 0x0000,0x0001 (lane 1), valid_o=10 each, then all states = 0x00010000.
REQ-040 Write sym 7 freq=1 cum=5; send 7,7,7 -> third symbol emits valid_o=01 enc_o=0x0005 lane_o=0, and lane0 x ends at 0x00100005.
REQ-041 Hold ready_i=0 for 10 cycles during the REQ-040 emit -> enc_o/valid_o stable, then transfer on ready_i=1 and a single word only.
REQ-042 restart_i and valid_i high together -> flush only, symbol not consumed; with RANS_ENC_FREQ_CHECK_EN a freq=0 symbol -> error_o one-cycle pulse and lane pointer unchanged.
REQ-043 Assert rst_i during DIV -> outputs at reset values immediately, and the next encode matches REQ-038.
